uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001: The block SHALL have parameter NUM_DATA_BITS, default 8, giving data bits per frame (legal range 2..16).
REQ-002: The block SHALL have parameter CLKS_PER_BIT, default 10, giving clock cycles per serial bit (legal range 2..1023).
REQ-003: The block SHALL have parameter PARITY_EN, default 0; when 1, a parity bit SHALL follow the data bits.
REQ-004: The block SHALL have parameter PARITY_ODD, default 0: 0 means even parity, 1 means odd parity.
REQ-005: The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-006: The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007: The block SHALL have port tx_valid, input, 1 bit: a frame request is present.
REQ-008: The block SHALL have port tx_data, input, NUM_DATA_BITS bits: the payload, sampled at accept.
REQ-009: The block SHALL have port tx_ready, output, 1 bit: the block can accept a request.
REQ-010: The block SHALL have port tx_out, output, 1 bit: the serial line; idle level is 1.
REQ-011: The block SHALL have port tx_done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-012: An accept SHALL occur on a posedge where tx_valid=1 and tx_ready=1; tx_data SHALL be latched on that edge.
REQ-013: tx_ready SHALL be 1 only in state IDLE; tx_valid seen while tx_ready=0 SHALL be ignored, and no data SHALL be latched.
REQ-014: The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, with transitions as follows.
  - IDLE->START on accept.
  - START->DATA after CLKS_PER_BIT cycles.
  - DATA->PARITY (PARITY_EN=1) or DATA->STOP (PARITY_EN=0) after NUM_DATA_BITS bit periods.
  - PARITY->STOP after one bit period.
  - STOP->IDLE after one bit period.
REQ-015: tx_out SHALL be registered and driven per state:
  - IDLE: 1.
  - START: 0.
  - DATA: data bits LSB first.
  - PARITY: the parity bit.
  - STOP: 1.
REQ-016: tx_out SHALL go low in the first cycle after the accept edge, and each bit SHALL be held exactly CLKS_PER_BIT cycles.
REQ-017: The parity bit SHALL equal the XOR of the latched data, inverted when PARITY_ODD=1.
REQ-018: Frame length SHALL be (2+NUM_DATA_BITS+PARITY_EN)*CLKS_PER_BIT cycles, counted from the cycle after accept.
REQ-019: tx_done SHALL be 1 for exactly one cycle, namely the first IDLE cycle after STOP, and tx_ready SHALL be 1 in that same cycle.
REQ-020: A request accepted in the tx_done cycle SHALL start its start bit in the next cycle, giving back-to-back frames with exactly one extra idle-high cycle.
REQ-021: The bit-period counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 on each bit boundary.
REQ-022: The bit-index counter SHALL count 0..NUM_DATA_BITS-1 and SHALL be cleared on entry to DATA.
REQ-023: Changes on tx_data after accept SHALL NOT affect the frame in progress.

Reset
REQ-024: While rst=1, the block SHALL immediately force the following, independent of clk:
  - state=IDLE, tx_out=1, tx_ready=1, tx_done=0.
  - all counters=0.
  - shift register=all ones.
REQ-025: A reset mid-frame SHALL abort the frame with no tx_done pulse, and the line SHALL return to 1 immediately.
REQ-026: The first accept after rst deasserts SHALL be possible on the first posedge with rst=0.

Structure
REQ-027: Package uart_pkg SHALL hold the following, shared with the receiver path:
  - the state enum typedef tx_state_t.
  - default constants for NUM_DATA_BITS and CLKS_PER_BIT.
  - the idle-level constant.
REQ-028: Sub-module flex_pts_sr SHALL be a parameterized parallel-to-serial shift register with the following properties:
  - LSB-first shifting.
  - load and shift_enable inputs, with load taking priority.
  - reset value all ones.
  - serial_out equal to bit 0.
REQ-029: uart_tx SHALL instantiate one flex_pts_sr and hold the FSM, the two counters and the parity register.

Verification (NUM_DATA_BITS=8, CLKS_PER_BIT=10 unless stated)
REQ-030: Reset: assert rst asynchronously between edges -> tx_out=1, tx_ready=1 and tx_done=0 immediately.
REQ-031: Send 0xA5 with PARITY_EN=0 -> tx_out = 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles; tx_done high in cycle 101 after accept.
REQ-032: Send 0x07 with PARITY_EN=1, PARITY_ODD=0 -> parity bit=1, frame 110 cycles; repeat with PARITY_ODD=1 -> parity bit=0.
REQ-033: Hold tx_valid=1 with 0x3C then 0xC3 -> second start bit begins exactly 1 idle cycle after the first stop bit, and tx_done pulses once per frame.
REQ-034: Pulse tx_valid with 0xFF during frame 0x00, and change tx_data mid-frame -> no second frame starts, and the output stays 0x00.
REQ-035: Assert rst during bit 3 of DATA -> tx_out=1 at once with no tx_done; a new 0x55 accepted after release transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, default framing constants.
// Used by both the transmitter and the receiver path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DEF_NUM_DATA_BITS = 8;
  localparam int DEF_CLKS_PER_BIT  = 10;

  localparam logic IDLE_LEVEL = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/flex_pts_sr.sv
// Parallel-in, serial-out shift register, LSB first.
// Vacated bits fill with the idle line level.
module flex_pts_sr
  import uart_pkg::*;
#(
  parameter int NUM_BITS = DEF_NUM_DATA_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                shift_enable,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                serial_out
);

  logic [NUM_BITS-1:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '1;
    end else if (load) begin
      q <= parallel_in;
    end else if (shift_enable) begin
      q <= {IDLE_LEVEL, q[NUM_BITS-1:1]};
    end
  end

  assign serial_out = q[0];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit.
// Line output is registered; tx_done pulses on the first idle cycle.
module uart_tx
  import uart_pkg::*;
#(
  parameter int NUM_DATA_BITS = DEF_NUM_DATA_BITS,
  parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
  parameter int PARITY_EN     = 0,
  parameter int PARITY_ODD    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tx_valid,
  input  logic [NUM_DATA_BITS-1:0] tx_data,
  output logic                     tx_ready,
  output logic                     tx_out,
  output logic                     tx_done
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int IW = cnt_width(NUM_DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DATA_BITS - 1);

  localparam logic HAS_PARITY = (PARITY_EN != 0);
  localparam logic ODD_PARITY = (PARITY_ODD != 0);

  tx_state_t state;
  tx_state_t state_next;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_next;

  logic parity;
  logic parity_next;
  logic line_next;
  logic done_next;

  logic load;
  logic shift;
  logic sr_out;
  logic accept;
  logic bit_end;

  assign tx_ready = (state == IDLE);
  assign accept   = tx_valid & tx_ready;
  assign bit_end  = (cnt == CNT_LAST);

  flex_pts_sr #(
    .NUM_BITS(NUM_DATA_BITS)
  ) u_sr (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .shift_enable(shift),
    .parallel_in (tx_data),
    .serial_out  (sr_out)
  );

  always_comb begin
    state_next  = state;
    cnt_next    = bit_end ? '0 : cnt + 1'b1;
    idx_next    = idx;
    parity_next = parity;
    line_next   = tx_out;
    done_next   = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_next  = '0;
        line_next = IDLE_LEVEL;
        if (accept) begin
          state_next  = START;
          line_next   = 1'b0;
          load        = 1'b1;
          parity_next = (^tx_data) ^ ODD_PARITY;
        end
      end
      START: begin
        // Shift here so bit 0 of the register always holds the next data bit.
        if (bit_end) begin
          state_next = DATA;
          idx_next   = '0;
          line_next  = sr_out;
          shift      = 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx == IDX_LAST) begin
            if (HAS_PARITY) begin
              state_next = PARITY;
              line_next  = parity;
            end else begin
              state_next = STOP;
              line_next  = IDLE_LEVEL;
            end
          end else begin
            idx_next  = idx + 1'b1;
            line_next = sr_out;
            shift     = 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          line_next  = IDLE_LEVEL;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          line_next  = IDLE_LEVEL;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        line_next  = IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      parity  <= 1'b0;
      tx_out  <= IDLE_LEVEL;
      tx_done <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      idx     <= idx_next;
      parity  <= parity_next;
      tx_out  <= line_next;
      tx_done <= done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three instances (no parity, even, odd).
// Expected frames are queued at accept; per-DUT monitors check the line.
module tb_uart_tx;

  localparam int CPB = 10;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] vld;
  logic [7:0] dat [3];
  logic [2:0] rdy;
  logic [2:0] line;
  logic [2:0] done;
  logic [2:0] active;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.NUM_DATA_BITS(8), .CLKS_PER_BIT(CPB),
            .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst(rst), .tx_valid(vld[0]), .tx_data(dat[0]),
    .tx_ready(rdy[0]), .tx_out(line[0]), .tx_done(done[0]));

  uart_tx #(.NUM_DATA_BITS(8), .CLKS_PER_BIT(CPB),
            .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .tx_valid(vld[1]), .tx_data(dat[1]),
    .tx_ready(rdy[1]), .tx_out(line[1]), .tx_done(done[1]));

  uart_tx #(.NUM_DATA_BITS(8), .CLKS_PER_BIT(CPB),
            .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst(rst), .tx_valid(vld[2]), .tx_data(dat[2]),
    .tx_ready(rdy[2]), .tx_out(line[2]), .tx_done(done[2]));

  function automatic bit has_par(input int id);
    return id != 0;
  endfunction

  function automatic bit is_odd(input int id);
    return id == 2;
  endfunction

  // Reference frame: start, data LSB first, optional parity, stop.
  function automatic logic exp_bit(input int id, input logic [7:0] d,
                                   input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && has_par(id))
      return (($countones(d) % 2) == 1) ^ is_odd(id);
    return 1'b1;
  endfunction

  function automatic void push(input int id, input exp_t e);
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int qsize(input int id);
    case (id)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t pop(input int id);
    case (id)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic check(input string name, input int id,
                       input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (cycle %0d)",
               name, id, act, req, cyc);
    end
  endtask

  task automatic send(input int id, input logic [7:0] d,
                      input bit hold, input bit now);
    int t;
    exp_t e;
    t = 0;
    if (!now) @(negedge clk);
    vld[id] = 1'b1;
    dat[id] = d;
    while (!rdy[id] && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("accept_in_time", id, int'(rdy[id]), 1);
    if (!rdy[id]) begin
      vld[id] = 1'b0;
      return;
    end
    e.data  = d;
    e.start = cyc + 1;
    push(id, e);
    @(posedge clk);
    if (!hold) begin
      #1;
      vld[id] = 1'b0;
      dat[id] = 8'($urandom);
    end
  endtask

  task automatic monitor(input int id);
    exp_t e;
    int   nb;
    int   bad;
    int   busy;
    bit   abort;
    logic expb;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (line[id] !== 1'b0) begin
        check("idle_no_done", id, int'(done[id]), 0);
        continue;
      end
      check("frame_expected", id, int'(qsize(id) > 0), 1);
      if (qsize(id) == 0) begin
        for (int t = 0; t < 400 && !done[id] && !rst; t++)
          @(negedge clk);
        continue;
      end
      active[id] = 1'b1;
      e = pop(id);
      check("start_cycle", id, cyc, e.start);
      nb    = has_par(id) ? 11 : 10;
      abort = 1'b0;
      busy  = 0;
      for (int k = 0; k < nb && !abort; k++) begin
        bad  = 0;
        expb = exp_bit(id, e.data, k);
        for (int c = 0; c < CPB; c++) begin
          if (k != 0 || c != 0) @(negedge clk);
          if (rst) begin
            abort = 1'b1;
            break;
          end
          if (line[id] !== expb) bad++;
          if (rdy[id] !== 1'b0 || done[id] !== 1'b0) busy++;
        end
        if (!abort)
          check($sformatf("bit%0d_bad_cycles", k), id, bad, 0);
      end
      if (!abort) begin
        check("busy_ready_or_done", id, busy, 0);
        @(negedge clk);
        if (!rst) begin
          check("done_pulse", id, int'(done[id]), 1);
          check("ready_at_done", id, int'(rdy[id]), 1);
          check("line_high_at_done", id, int'(line[id]), 1);
        end
      end
      active[id] = 1'b0;
    end
  endtask

  initial begin
    rst    = 1'b1;
    vld    = '0;
    active = '0;
    for (int i = 0; i < 3; i++) dat[i] = '0;
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none

    #12;
    for (int i = 0; i < 3; i++) begin
      check("rst_line", i, int'(line[i]), 1);
      check("rst_ready", i, int'(rdy[i]), 1);
      check("rst_done", i, int'(done[i]), 0);
    end

    // Accept on the very first edge after reset release.
    @(negedge clk);
    #2 rst = 1'b0;
    send(0, 8'hA5, 1'b0, 1'b1);

    // Requests while busy and data changes mid-frame must be ignored.
    send(0, 8'h00, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    vld[0] = 1'b1;
    dat[0] = 8'hFF;
    @(negedge clk);
    vld[0] = 1'b0;
    dat[0] = 8'h5A;

    send(0, 8'h3C, 1'b1, 1'b0);
    send(0, 8'hC3, 1'b0, 1'b0);

    // Reset during data bit 3.
    send(0, 8'h96, 1'b0, 1'b0);
    repeat (44) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_line", 0, int'(line[0]), 1);
    check("midrst_ready", 0, int'(rdy[0]), 1);
    check("midrst_done", 0, int'(done[0]), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    send(0, 8'h55, 1'b0, 1'b0);

    send(1, 8'h07, 1'b0, 1'b0);
    send(2, 8'h07, 1'b0, 1'b0);

    fork
      for (int i = 0; i < 6; i++) begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
        send(0, 8'($urandom), (i < 5) && ($urandom_range(0, 1) == 1), 1'b0);
      end
      for (int i = 0; i < 6; i++) begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
        send(1, 8'($urandom), (i < 5) && ($urandom_range(0, 1) == 1), 1'b0);
      end
      for (int i = 0; i < 6; i++) begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
        send(2, 8'($urandom), (i < 5) && ($urandom_range(0, 1) == 1), 1'b0);
      end
    join

    for (int t = 0; t < 2000 &&
         (qsize(0) + qsize(1) + qsize(2) != 0 || active != 0); t++)
      @(negedge clk);
    check("frames_outstanding", 0, qsize(0) + qsize(1) + qsize(2), 0);
    check("monitors_idle", 0, int'(active), 0);
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
